// File: rtl/klavye_pkg.sv
// klavye_pkg: definitions shared by the keystroke transmitter and the
// listener's bench.
//   BYTE_W                      - width of one keystroke byte
//   VARSAYILAN_KARAKTER_SAYISI  - default bytes per code word
//   durum_t                     - transmitter FSM states
//   sayac_genisligi()           - gap counter width for a given BOSLUK (min 1)
package klavye_pkg;

    localparam int BYTE_W                     = 8;
    localparam int VARSAYILAN_KARAKTER_SAYISI = 4;

    typedef enum logic [2:0] {
        BOSTA,
        PROGRAM,
        GONDER,
        ARA,
        KILIT,
        BITTI
    } durum_t;

    function automatic int sayac_genisligi(input int bosluk);
        return (bosluk > 0) ? $clog2(bosluk + 1) : 1;
    endfunction

endpackage

// File: rtl/bosluk_sayaci.sv
// bosluk_sayaci: loadable down-counter timing the idle gap between
// character strobes.
//   clk, rst_n  - clock, asynchronous active-low reset
//   yukle       - load deger into the counter (has priority over azalt)
//   deger       - load value
//   azalt       - decrement by one, saturating at zero
//   sifir       - counter is zero (gap finished)
module bosluk_sayaci #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         yukle,
    input  logic [W-1:0] deger,
    input  logic         azalt,
    output logic         sifir
);

    logic [W-1:0] sayac;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sayac <= '0;
        end else if (yukle) begin
            sayac <= deger;
        end else if (azalt && (sayac != '0)) begin
            sayac <= sayac - 1'b1;
        end
    end

    assign sifir = (sayac == '0);

endmodule

// File: rtl/klavye_gonder.sv
// klavye_gonder: serializes a code word into the keyboard listener's byte
// interfaces. Character mode sends one byte per karakter_aktif strobe, LSB
// byte first, with BOSLUK idle cycles between strobes and no strobe while
// kitle is high. Program mode writes the word MSB byte first on consecutive
// sifre_degis cycles.
//
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   yukle, mod, kod  - load strobe, mode (1 = program), code word
//   kitle            - listener lock status
//   karakter, karakter_aktif    - character byte and its one-cycle strobe
//   sifre_kanali, sifre_degis   - password byte and its write enable
//   mesgul, bitti    - busy flag, one-cycle completion pulse
//   durum            - current FSM state (debug)
//
// Handshake: yukle is accepted only in a cycle where mesgul is 0; kod and
// mod are latched on that edge. mesgul rises the next cycle and falls in the
// cycle bitti pulses. yukle while mesgul=1 is dropped.
//
// Build option KLAVYE_TEKRAR_EN: a kitle rise in GONDER/ARA/KILIT abandons
// the partly sent word and restarts it from byte 0 after unlock. Without it
// the transfer resumes from the held byte index.
module klavye_gonder
    import klavye_pkg::*;
#(
    parameter int BOSLUK          = 2,
    parameter int KARAKTER_SAYISI = VARSAYILAN_KARAKTER_SAYISI
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              yukle,
    input  logic                              mod,
    input  logic [BYTE_W*KARAKTER_SAYISI-1:0] kod,
    input  logic                              kitle,
    output logic [BYTE_W-1:0]                 karakter,
    output logic                              karakter_aktif,
    output logic [BYTE_W-1:0]                 sifre_kanali,
    output logic                              sifre_degis,
    output logic                              mesgul,
    output logic                              bitti,
    output durum_t                            durum
);

    localparam int W       = BYTE_W * KARAKTER_SAYISI;
    localparam int IDX_W   = (KARAKTER_SAYISI > 1) ? $clog2(KARAKTER_SAYISI) : 1;
    localparam int SAYAC_W = sayac_genisligi(BOSLUK);
    // The counter is loaded on the strobe edge and ARA exits when it reads
    // zero, so loading BOSLUK-1 yields exactly BOSLUK idle cycles.
    localparam logic [SAYAC_W-1:0] ARA_YUK = SAYAC_W'((BOSLUK > 0) ? BOSLUK - 1 : 0);
    localparam logic [IDX_W-1:0]   SON_IDX = IDX_W'(KARAKTER_SAYISI - 1);

    logic [W-1:0]      kelime;
    logic [IDX_W-1:0]  idx;
    logic              son_bayt;
    logic              strobe_simdi;
    logic [BYTE_W-1:0] gonder_bayt;
    logic [BYTE_W-1:0] prog_bayt;
    logic              sayac_yukle;
    logic              sayac_azalt;
    logic              sayac_sifir;
`ifdef KLAVYE_TEKRAR_EN
    logic              kitle_q;
`endif

    // The first byte of a word goes out on the accepting edge itself, taken
    // straight from kod, so the strobe is visible the cycle after yukle.
    always_comb begin
        son_bayt = (idx == SON_IDX);
        if (durum == BOSTA) begin
            gonder_bayt = kod[BYTE_W-1:0];
            prog_bayt   = kod[W-1 -: BYTE_W];
        end else begin
            gonder_bayt = kelime[BYTE_W*int'(idx) +: BYTE_W];
            prog_bayt   = kelime[BYTE_W*(KARAKTER_SAYISI-1-int'(idx)) +: BYTE_W];
        end
        strobe_simdi = !kitle && (((durum == BOSTA) && yukle && !mod) || (durum == GONDER));
        sayac_yukle  = strobe_simdi && !son_bayt;
        sayac_azalt  = (durum == ARA);
    end

    bosluk_sayaci #(
        .W (SAYAC_W)
    ) u_bosluk_sayaci (
        .clk   (clk),
        .rst_n (rst_n),
        .yukle (sayac_yukle),
        .deger (ARA_YUK),
        .azalt (sayac_azalt),
        .sifir (sayac_sifir)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            durum          <= BOSTA;
            idx            <= '0;
            kelime         <= '0;
            karakter       <= '0;
            karakter_aktif <= 1'b0;
            sifre_kanali   <= '0;
            sifre_degis    <= 1'b0;
            mesgul         <= 1'b0;
            bitti          <= 1'b0;
`ifdef KLAVYE_TEKRAR_EN
            kitle_q        <= 1'b0;
`endif
        end else begin
            karakter_aktif <= 1'b0;
            sifre_degis    <= 1'b0;
            bitti          <= 1'b0;
`ifdef KLAVYE_TEKRAR_EN
            kitle_q        <= kitle;
`endif
            case (durum)
                BOSTA: begin
                    if (yukle) begin
                        kelime <= kod;
                        mesgul <= 1'b1;
                        if (mod) begin
                            sifre_degis  <= 1'b1;
                            sifre_kanali <= prog_bayt;
                            if (son_bayt) begin
                                durum <= BITTI;
                            end else begin
                                idx   <= idx + 1'b1;
                                durum <= PROGRAM;
                            end
                        end else if (kitle) begin
                            durum <= KILIT;
                        end
                    end
                end
                PROGRAM: begin
                    // kitle deliberately not consulted here.
                    sifre_degis  <= 1'b1;
                    sifre_kanali <= prog_bayt;
                    if (son_bayt) begin
                        durum <= BITTI;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                GONDER: begin
                    if (kitle) begin
                        durum <= KILIT;
`ifdef KLAVYE_TEKRAR_EN
                        idx   <= '0;
`endif
                    end
                end
                ARA: begin
                    if (sayac_sifir) begin
                        durum <= GONDER;
                    end
`ifdef KLAVYE_TEKRAR_EN
                    if (kitle && !kitle_q) begin
                        durum <= KILIT;
                        idx   <= '0;
                    end
`endif
                end
                KILIT: begin
                    if (!kitle) begin
                        durum <= GONDER;
                    end
                end
                BITTI: begin
                    bitti  <= 1'b1;
                    mesgul <= 1'b0;
                    idx    <= '0;
                    durum  <= BOSTA;
                end
                default: durum <= BOSTA;
            endcase

            // Character strobe, shared by the BOSTA accept path and GONDER.
            if (strobe_simdi) begin
                karakter_aktif <= 1'b1;
                karakter       <= gonder_bayt;
                if (son_bayt) begin
                    durum <= BITTI;
                end else begin
                    idx   <= idx + 1'b1;
                    durum <= (BOSLUK > 0) ? ARA : GONDER;
                end
            end
        end
    end

endmodule

// File: tb/tb_klavye_gonder.sv
// tb_klavye_gonder: self-checking bench for klavye_gonder (BOSLUK=2, 4 bytes).
// A negedge monitor logs every strobe; test tasks push expected bytes into
// queues and pop/compare them against the log once the word completes.
// Cycle numbers are relative to the accepting edge: cycle 1 is the first
// cycle after the edge that sampled yukle.
module tb_klavye_gonder;
    import klavye_pkg::*;

    localparam int BOS = 2;
    localparam int KS  = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        yukle = 1'b0;
    logic        mod   = 1'b0;
    logic [31:0] kod   = '0;
    logic        kitle = 1'b0;
    logic [7:0]  karakter;
    logic        karakter_aktif;
    logic [7:0]  sifre_kanali;
    logic        sifre_degis;
    logic        mesgul;
    logic        bitti;
    durum_t      durum;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    logic [7:0] exp_q[$];
    logic [7:0] sif_exp_q[$];

    // Monitor logs (written only by the monitor).
    logic [7:0] kar_bayt_q[$];
    int         kar_cyc_q[$];
    logic [7:0] sif_bayt_q[$];
    int         sif_cyc_q[$];
    int         bitti_cyc_q[$];
    logic [31:0] sr  = '0;   // listener character shift register model
    logic [31:0] pwd = '0;   // listener stored password model

    klavye_gonder #(
        .BOSLUK          (BOS),
        .KARAKTER_SAYISI (KS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .yukle          (yukle),
        .mod            (mod),
        .kod            (kod),
        .kitle          (kitle),
        .karakter       (karakter),
        .karakter_aktif (karakter_aktif),
        .sifre_kanali   (sifre_kanali),
        .sifre_degis    (sifre_degis),
        .mesgul         (mesgul),
        .bitti          (bitti),
        .durum          (durum)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (karakter_aktif) begin
                kar_bayt_q.push_back(karakter);
                kar_cyc_q.push_back(cyc);
                sr = {karakter, sr[31:8]};
            end
            if (sifre_degis) begin
                sif_bayt_q.push_back(sifre_kanali);
                sif_cyc_q.push_back(cyc);
                pwd = {pwd[23:0], sifre_kanali};
            end
            if (bitti) bitti_cyc_q.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic yukle_ver(input logic m, input logic [31:0] k);
        @(posedge clk); #1;
        yukle = 1'b1; mod = m; kod = k;
        @(posedge clk); #1;
        acc_cyc = cyc;
        yukle = 1'b0;
    endtask

    task automatic bitti_bekle(input int bas, output int rel);
        rel = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (bitti_cyc_q.size() > bas) begin
                rel = bitti_cyc_q[bas] - acc_cyc + 1;
                break;
            end
        end
        checks++;
        if (rel < 0) begin
            failures++;
            $display("FAIL bitti_timeout: got no bitti, required bitti within 200 cycles");
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({karakter, karakter_aktif, sifre_kanali, sifre_degis, mesgul, bitti} !== 20'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {karakter, karakter_aktif, sifre_kanali, sifre_degis, mesgul, bitti});
        end
        checks++;
        if (durum !== BOSTA) begin
            failures++;
            $display("FAIL reset_state: got %0d, required %0d", durum, BOSTA);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_program(input logic [31:0] k);
        int sb, kb, bb, rel;
        logic [7:0] e;
        sb = sif_bayt_q.size(); kb = kar_bayt_q.size(); bb = bitti_cyc_q.size();
        for (int i = KS - 1; i >= 0; i--) sif_exp_q.push_back(k[8*i +: 8]);
        yukle_ver(1'b1, k);
        checks++;
        if (mesgul !== 1'b1) begin
            failures++;
            $display("FAIL prog_mesgul: got %b, required 1", mesgul);
        end
        bitti_bekle(bb, rel);
        checks++;
        if (rel != KS + 1) begin
            failures++;
            $display("FAIL prog_bitti_cycle: got %0d, required %0d", rel, KS + 1);
        end
        checks++;
        if (mesgul !== 1'b0) begin
            failures++;
            $display("FAIL prog_mesgul_done: got %b, required 0", mesgul);
        end
        checks++;
        if (sif_bayt_q.size() - sb != KS || kar_bayt_q.size() != kb) begin
            failures++;
            $display("FAIL prog_count: got %0d pw / %0d char, required %0d / 0",
                     sif_bayt_q.size() - sb, kar_bayt_q.size() - kb, KS);
        end
        for (int i = 0; i < KS && sb + i < sif_bayt_q.size(); i++) begin
            e = sif_exp_q.pop_front();
            checks++;
            if (sif_bayt_q[sb+i] !== e) begin
                failures++;
                $display("FAIL prog_byte%0d: got %h, required %h", i, sif_bayt_q[sb+i], e);
            end
            checks++;
            if (sif_cyc_q[sb+i] - acc_cyc + 1 != i + 1) begin
                failures++;
                $display("FAIL prog_cycle%0d: got %0d, required %0d", i, sif_cyc_q[sb+i] - acc_cyc + 1, i + 1);
            end
        end
        sif_exp_q.delete();
    endtask

    task automatic test_character();
        logic [31:0] kodlar[3];
        int kb, bb, rel, req;
        logic [7:0] e;
        kodlar[0] = 32'h11223344;
        kodlar[1] = $urandom();
        kodlar[2] = $urandom();
        for (int w = 0; w < 3; w++) begin
            kb = kar_bayt_q.size(); bb = bitti_cyc_q.size();
            for (int i = 0; i < KS; i++) exp_q.push_back(kodlar[w][8*i +: 8]);
            yukle_ver(1'b0, kodlar[w]);
            bitti_bekle(bb, rel);
            req = KS + (KS - 1) * BOS + 1;
            checks++;
            if (rel != req) begin
                failures++;
                $display("FAIL char_bitti_cycle w%0d: got %0d, required %0d", w, rel, req);
            end
            checks++;
            if (kar_bayt_q.size() - kb != KS) begin
                failures++;
                $display("FAIL char_count w%0d: got %0d, required %0d", w, kar_bayt_q.size() - kb, KS);
            end
            for (int i = 0; i < KS && kb + i < kar_bayt_q.size(); i++) begin
                e = exp_q.pop_front();
                checks++;
                if (kar_bayt_q[kb+i] !== e) begin
                    failures++;
                    $display("FAIL char_byte w%0d b%0d: got %h, required %h", w, i, kar_bayt_q[kb+i], e);
                end
                checks++;
                if (kar_cyc_q[kb+i] - acc_cyc + 1 != 1 + i * (BOS + 1)) begin
                    failures++;
                    $display("FAIL char_cycle w%0d b%0d: got %0d, required %0d", w, i,
                             kar_cyc_q[kb+i] - acc_cyc + 1, 1 + i * (BOS + 1));
                end
            end
            exp_q.delete();
            checks++;
            if (sr !== kodlar[w]) begin
                failures++;
                $display("FAIL char_shiftreg w%0d: got %h, required %h", w, sr, kodlar[w]);
            end
        end
    endtask

    task automatic test_ignored_yukle();
        int kb, bb, rel;
        logic [7:0] e;
        kb = kar_bayt_q.size(); bb = bitti_cyc_q.size();
        for (int i = 0; i < KS; i++) exp_q.push_back(8'(32'h11223344 >> (8*i)));
        yukle_ver(1'b0, 32'h11223344);
        @(posedge clk); #1;
        yukle = 1'b1; mod = 1'b0; kod = 32'hFFFFFFFF;
        @(posedge clk); #1;
        yukle = 1'b0;
        bitti_bekle(bb, rel);
        checks++;
        if (rel != KS + (KS - 1) * BOS + 1) begin
            failures++;
            $display("FAIL ign_bitti_cycle: got %0d, required %0d", rel, KS + (KS - 1) * BOS + 1);
        end
        checks++;
        if (kar_bayt_q.size() - kb != KS) begin
            failures++;
            $display("FAIL ign_count: got %0d, required %0d", kar_bayt_q.size() - kb, KS);
        end
        for (int i = 0; i < KS && kb + i < kar_bayt_q.size(); i++) begin
            e = exp_q.pop_front();
            checks++;
            if (kar_bayt_q[kb+i] !== e) begin
                failures++;
                $display("FAIL ign_byte%0d: got %h, required %h", i, kar_bayt_q[kb+i], e);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_kitle();
        int kb, bb, rel, n, r;
        logic [7:0] e;
        kb = kar_bayt_q.size(); bb = bitti_cyc_q.size();
`ifdef KLAVYE_TEKRAR_EN
        exp_q.push_back(8'h44);
`endif
        exp_q.push_back(8'h44); exp_q.push_back(8'h33);
        exp_q.push_back(8'h22); exp_q.push_back(8'h11);
        n = exp_q.size();
        yukle_ver(1'b0, 32'h11223344);
        @(posedge clk); #1;              // cycle 2
        @(posedge clk); #1;              // cycle 3
        kitle = 1'b1;
        repeat (6) @(posedge clk);
        #1;                              // cycle 9
        kitle = 1'b0;
        bitti_bekle(bb, rel);
        checks++;
        if (kar_bayt_q.size() - kb != n) begin
            failures++;
            $display("FAIL kitle_count: got %0d, required %0d", kar_bayt_q.size() - kb, n);
        end
        for (int i = 0; i < n && kb + i < kar_bayt_q.size(); i++) begin
            e = exp_q.pop_front();
            checks++;
            if (kar_bayt_q[kb+i] !== e) begin
                failures++;
                $display("FAIL kitle_byte%0d: got %h, required %h", i, kar_bayt_q[kb+i], e);
            end
            r = kar_cyc_q[kb+i] - acc_cyc + 1;
            checks++;
            if (r >= 4 && r <= 9) begin
                failures++;
                $display("FAIL kitle_locked_strobe: got strobe at cycle %0d, required none in 4..9", r);
            end
        end
        exp_q.delete();
        checks++;
        if (sr !== 32'h11223344) begin
            failures++;
            $display("FAIL kitle_shiftreg: got %h, required 11223344", sr);
        end
    endtask

    task automatic test_reset_mid();
        int kb, k2, bb;
        kb = kar_bayt_q.size();
        yukle_ver(1'b0, 32'h11223344);
        repeat (4) @(posedge clk);
        #1;                              // cycle 5
        rst_n = 1'b0;
        #1;
        checks++;
        if ({karakter, karakter_aktif, sifre_kanali, sifre_degis, mesgul, bitti} !== 20'h0 || durum !== BOSTA) begin
            failures++;
            $display("FAIL midreset_outputs: got %h state %0d, required 0 state %0d",
                     {karakter, karakter_aktif, sifre_kanali, sifre_degis, mesgul, bitti}, durum, BOSTA);
        end
        checks++;
        if (kar_bayt_q.size() - kb != 2) begin
            failures++;
            $display("FAIL midreset_pre_count: got %0d, required 2", kar_bayt_q.size() - kb);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        k2 = kar_bayt_q.size(); bb = bitti_cyc_q.size();
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (kar_bayt_q.size() != k2 || bitti_cyc_q.size() != bb || mesgul !== 1'b0) begin
            failures++;
            $display("FAIL midreset_silent: got %0d strobes %0d bitti mesgul %b, required 0 0 0",
                     kar_bayt_q.size() - k2, bitti_cyc_q.size() - bb, mesgul);
        end
    endtask

    task automatic test_loopback();
        int bb, rel;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bb = bitti_cyc_q.size();
        yukle_ver(1'b1, 32'hA1B2C3D4);
        bitti_bekle(bb, rel);
        checks++;
        if (pwd !== 32'hA1B2C3D4) begin
            failures++;
            $display("FAIL loop_password: got %h, required a1b2c3d4", pwd);
        end
        // Back-to-back: next load in the cycle right after bitti.
        bb = bitti_cyc_q.size();
        yukle_ver(1'b0, 32'hA1B2C3D4);
        bitti_bekle(bb, rel);
        checks++;
        if ((sr === pwd) !== 1'b1) begin
            failures++;
            $display("FAIL loop_guvenli_match: got 0 (sr %h), required 1", sr);
        end
        bb = bitti_cyc_q.size();
        yukle_ver(1'b0, 32'h00000000);
        bitti_bekle(bb, rel);
        checks++;
        if ((sr === pwd) !== 1'b0) begin
            failures++;
            $display("FAIL loop_guvenli_wrong: got 1 (sr %h), required 0", sr);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_program(32'hA1B2C3D4);
        test_character();
        test_ignored_yukle();
        test_kitle();
        test_reset_mid();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/klavye_gonder.md
Name: klavye_gonder

Overview:
- Transmit-side counterpart of the keyboard listener. Serializes a 32-bit code word into the listener's byte interfaces.
- Character mode drives the character stream: one byte per karakter_aktif strobe.
- Program mode drives the password channel: four consecutive sifre_degis cycles.
- Sits between the test/host controller and the listener. Honours the listener's kitle (lock) output so that no keystroke is sent while the listener is locked.

Parameters:
- BOSLUK, 2: idle cycles inserted between consecutive character strobes; 0 means back-to-back strobes.
- KARAKTER_SAYISI, 4: bytes per code word; the word width is 8*KARAKTER_SAYISI.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- yukle  in  1  load strobe, one cycle; accepted only when mesgul=0
- mod  in  1  sampled with yukle: 0 = character mode, 1 = password program mode
- kod  in  32  code word, sampled with yukle
- kitle  in  1  lock status from the listener
- karakter  out  8  character byte
- karakter_aktif  out  1  character valid strobe, one cycle per byte
- sifre_kanali  out  8  password byte
- sifre_degis  out  1  password write enable
- mesgul  out  1  busy; high from the cycle after an accepted yukle until bitti
- bitti  out  1  one-cycle completion pulse

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All outputs go to 0; FSM goes to BOSTA; byte index and gap counter clear.
  - Reset mid-word abandons the word; no further strobes are produced.
- Outputs: all registered.
- Load handshake:
  - yukle with mesgul=0 latches kod and mod.
  - yukle with mesgul=1 is ignored; the latched word is unchanged.
- Character mode byte order: LSB byte first, i.e. kod[7:0], kod[15:8], kod[23:16], kod[31:24]. In this order the listener's right-shift register holds exactly kod after the 4th strobe.
- Program mode byte order: MSB byte first, i.e. kod[31:24] down to kod[7:0], on four consecutive cycles.
  - sifre_degis stays high for exactly 4 cycles. kitle is ignored.
  - The listener accepts password bytes only in its first four cycles after reset, so the controller issues program mode immediately after reset.
- FSM states:
  - BOSTA:
    - yukle & mod=1 -> PROGRAM.
    - yukle & mod=0 -> GONDER.
  - PROGRAM: drive one byte per cycle; after byte 3 -> BITTI.
  - GONDER:
    - kitle=1 -> KILIT; no strobe is emitted.
    - Otherwise emit karakter with karakter_aktif=1 for one cycle and advance the index.
    - Then: last byte -> BITTI; BOSLUK>0 -> ARA; else stay in GONDER.
  - ARA: count BOSLUK idle cycles, then -> GONDER. kitle during ARA is not sampled; it is checked on entry to GONDER.
  - KILIT: hold the byte index; when kitle=0 -> GONDER on the next cycle.
  - BITTI: bitti=1 for one cycle, mesgul=0 -> BOSTA.
- Latency:
  - The first strobe (either mode) appears in the cycle after the accepted yukle.
  - Character-mode word with kitle low: 4 + 3*BOSLUK cycles of strobes/gaps, plus 1 cycle for bitti.
- karakter and sifre_kanali hold their last value when their strobe is low.
- Simultaneous events: kitle rising in the same cycle as a scheduled strobe suppresses that strobe, and the same byte is sent after unlock.
- Counter width: the gap counter is $clog2(BOSLUK+1) bits, minimum 1. The byte index is 2 bits and does not wrap within a word.

Optional Feature:
- Macro: KLAVYE_TEKRAR_EN
- Defined: a kitle rising edge during GONDER/ARA/KILIT aborts the current word. After kitle falls, transmission restarts from byte 0, so the listener sees the full 4-byte word contiguously. bitti fires only after a clean, uninterrupted word.
- Undefined: resume from the held byte index, as above.

Decomposition:
- Package klavye_pkg:
  - FSM state enum: BOSTA, PROGRAM, GONDER, ARA, KILIT, BITTI.
  - BYTE_W=8 and default KARAKTER_SAYISI.
  - Shared with the listener's bench.
- Sub-module: bosluk_sayaci, a loadable down-counter producing a done flag for ARA. Everything else stays in klavye_gonder.

Test Plan:
- Reset release, yukle mod=1 kod=32'hA1B2C3D4 -> sifre_degis high for cycles 1-4 with sifre_kanali A1,B2,C3,D4; bitti in cycle 5.
- yukle mod=0 kod=32'h11223344, BOSLUK=2, kitle=0 -> strobes at cycles 1,4,7,10 carrying 44,33,22,11; bitti at cycle 11.
- Same word, kitle high for cycles 3-8 -> byte 33 is delayed until the cycle after kitle falls; byte order unchanged. With KLAVYE_TEKRAR_EN, bytes 44,33,22,11 are resent in full after unlock.
- yukle pulsed again at cycle 2 with kod=32'hFFFFFFFF -> ignored; output bytes remain 44,33,22,11.
- rst_n low at cycle 5 mid-word -> all outputs 0 immediately; no strobe after release until the next yukle.
- Loopback with the listener (program 32'hA1B2C3D4, then send the same word in character mode) -> listener guvenli asserts; sending 32'h00000000 instead -> no guvenli.
